// File: rtl/pmem_arbiter.sv
// N-port line-request arbiter in front of a single physical-memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest port index wins.
module pmem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    input  logic                             pmem_resp,
    input  logic [LINE_WIDTH-1:0]            pmem_rdata,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [ADDR_WIDTH-1:0]            pmem_address,
    output logic [LINE_WIDTH-1:0]            pmem_wdata,
    output logic [GW-1:0]                    grant_id,
    output logic                             busy,
    output logic [1:0]                       dbg_state
);
    // Handshake: a port holds req_read/req_write until its req_resp pulse; req_resp is a
    // single-cycle pulse and req_rdata is only meaningful in that cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic                    pmem_read_q, pmem_read_d;
    logic                    pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0]   pmem_address_q, pmem_address_d;
    logic [LINE_WIDTH-1:0]   pmem_wdata_q, pmem_wdata_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [NUM_PORTS-1:0]    req_any;
    logic [GW-1:0]           win;
    logic                    win_found;

    assign req_any = req_read | req_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic [GW-1:0] ptr_q, ptr_d;

    // Search starts at the pointer and wraps, so the port after the last winner goes first.
    always_comb begin
        int idx;
        idx       = 0;
        win       = '0;
        win_found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!win_found && req_any[idx]) begin
                win_found = 1'b1;
                win       = GW'(idx);
            end
        end
    end
`else
    always_comb begin
        win       = '0;
        win_found = |req_any;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_any[k]) win = GW'(k);
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        grant_d        = grant_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d          = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d        = BUSY;
                    grant_d        = win;
                    pmem_address_d = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    pmem_wdata_d   = req_wdata[int'(win)*LINE_WIDTH +: LINE_WIDTH];
                    // A port raising both strobes is served as a write.
                    pmem_write_d   = req_write[win];
                    pmem_read_d    = req_read[win] & ~req_write[win];
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d          = (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
`endif
                end
            end
            BUSY: begin
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            grant_q        <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            grant_q        <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q          <= ptr_d;
`endif
        end
    end

    always_comb begin
        req_resp = '0;
        if (state_q == BUSY && pmem_resp) req_resp[grant_q] = 1'b1;
    end

    assign req_rdata    = pmem_rdata;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q != IDLE);
    assign dbg_state    = state_q;
endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Parametrised N-port arbiter between NUM_PORTS cache-side line requesters (I-cache, D-cache, later L2/prefetch ports) and the single physical-memory port. It succeeds the fixed two-port I/D arbiter with a configurable port count and widths. It adds round-robin fairness (compile-time selectable), registered pmem outputs and a grant-ID observation port. Exactly one line transaction is outstanding on pmem at any time.

## Interface
- NUM_PORTS, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, address width
- LINE_WIDTH, 256, cache line width in bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_read  in  NUM_PORTS  per-port line read request, held until that port's req_resp
- req_write  in  NUM_PORTS  per-port line write request, held until that port's req_resp
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*LINE_WIDTH  per-port write line, port i at [i*LINE_WIDTH +: LINE_WIDTH]
- req_resp  out  NUM_PORTS  one-hot completion pulse to the granted port
- req_rdata  out  LINE_WIDTH  read line, broadcast to all ports, valid when req_resp bit set
- pmem_resp  in  1  physical memory completion
- pmem_rdata  in  LINE_WIDTH  physical memory read line
- pmem_read  out  1  registered read strobe
- pmem_write  out  1  registered write strobe
- pmem_address  out  ADDR_WIDTH  registered address
- pmem_wdata  out  LINE_WIDTH  registered write line
- grant_id  out  $clog2(NUM_PORTS)  index of port currently owning pmem (valid while busy)
- busy  out  1  high in BUSY and DONE states

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: request vector r[i] = req_read[i] | req_write[i]. If r nonzero, select winner g, latch grant_id=g, pmem_address=req_addr[g], pmem_wdata=req_wdata[g], pmem_write=req_write[g], pmem_read=req_read[g] & ~req_write[g]; go BUSY. Else stay.
- Port asserting both read and write: treated as write.
- BUSY: hold all pmem outputs stable. On pmem_resp: req_resp[grant_id]=1 combinationally same cycle, req_rdata=pmem_rdata (passthrough, every cycle); clear pmem_read/pmem_write; go DONE.
- DONE: one recovery cycle so the served cache drops its request; no new grant; go IDLE.
- Requester dropping its request while BUSY: transaction still runs to pmem_resp; no abort; resp pulse still issued.
- pmem_resp in IDLE or DONE: ignored, no req_resp.
- Non-granted ports see req_resp=0 and must keep requests held.

## Timing
- Reset (async): state IDLE, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, grant_id=0, busy=0, req_resp=0, priority pointer=0. Reset mid-transaction aborts immediately; pmem strobes drop without waiting for pmem_resp.
- Request sampled in IDLE at edge t -> pmem strobe high from cycle t+1.
- pmem_resp at cycle r -> req_resp pulse in cycle r (one cycle), strobes low from r+1, DONE in r+1, IDLE in r+2, earliest next grant strobes in r+3.
- Minimum pmem-occupied cycles per transaction: 1 + pmem latency; back-to-back throughput one transaction per (pmem latency + 3) cycles.
- grant_id only changes on IDLE->BUSY.

## Configuration
- ARB_ROUND_ROBIN_EN defined: rotating priority. Pointer p (reset 0); search ports p, p+1, ..., wrapping modulo NUM_PORTS; first requester wins; on grant, p <= (g+1) mod NUM_PORTS. No starvation: a held request is served within NUM_PORTS grants.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins (port 0 = I-cache highest); pointer logic absent.

## Test plan
- Single read: port 1 req_read, addr 0x0000_0040, pmem_resp after 3 cycles with rdata 0xA5..A5 -> pmem_read high cycles 1-4 at 0x40, req_resp=2'b10 in resp cycle, req_rdata=0xA5..A5, busy low two cycles later.
- Simultaneous: NUM_PORTS=2, both ports request continuously, RR enabled -> grants 0,1,0,1; RR disabled -> port 0 every grant while held, port 1 only after port 0 drops.
- Write: port 0 req_write, addr 0x100, wdata 0x1234 -> pmem_write=1, pmem_read=0, pmem_wdata=0x1234; read+write both set on port 0 -> write issued.
- NUM_PORTS=4, RR, ports 1 and 3 requesting after grant to 2 -> port 3 served first, then 1 (wrap).
- Reset asserted while BUSY -> pmem_read/pmem_write/busy low same cycle without clock edge; stray pmem_resp afterwards -> req_resp stays 0.
- Requester drops request mid-BUSY -> pmem strobe held until pmem_resp, one req_resp pulse, then IDLE.
